scan_demux: RTL and testbench

- Receiving end of the 4-phase scan interface.
- The scan interface drives four one-hot select lines in the fixed order slot 0,1,2,3,0,... alongside a shared data bus.
- This block validates the select pattern, encodes it to a slot index and captures bus data into per-slot registers.
- It checks scan ordering and publishes a complete 4-slot frame once per full, in-order scan cycle.

---
 rtl/scan_demux_pkg.sv | 18 +
 rtl/scan_demux_if.sv | 27 ++
 rtl/scan_demux_onehot_enc4.sv | 19 +
 rtl/scan_demux.sv | 105 ++++++++++
 tb/tb_scan_demux.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/scan_demux_pkg.sv
// scan_demux_pkg: shared constants, FSM state type and one-hot legality helper
// for consumers of the 4-phase scan interface.
package scan_demux_pkg;

    localparam int unsigned NSLOT = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic onehot4(input logic [NSLOT-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/scan_demux_if.sv
// scan_demux_if: scan bus (select lines + shared data) and the frame/status
// outputs of the receiver.
//   master: drives sel/data_in, observes the receiver outputs
//   slave : the receiver (scan_demux)
interface scan_demux_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned ERR_W = 8
);
    logic [3:0]       sel;
    logic [W-1:0]     data_in;
    logic [4*W-1:0]   frame_out;
    logic             frame_valid;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       slot_idx;

    modport master (
        output sel, data_in,
        input  frame_out, frame_valid, locked, err, err_count, slot_idx
    );

    modport slave (
        input  sel, data_in,
        output frame_out, frame_valid, locked, err, err_count, slot_idx
    );
endinterface

// File: rtl/scan_demux_onehot_enc4.sv
// onehot_enc4: combinational 4-line select encoder.
//   sel   : select lines
//   legal : exactly one line high
//   idx   : position of the high line (only meaningful when legal)
module onehot_enc4
    import scan_demux_pkg::*;
(
    input  logic [NSLOT-1:0] sel,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        legal = onehot4(sel);
        idx   = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (sel[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/scan_demux.sv
// scan_demux: receiving end of the 4-phase scan interface. Validates the
// select pattern, captures bus data per slot and publishes a 4-slot frame
// once per complete in-order scan.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : scan_demux_if slave (sel, data_in in; frame_out, frame_valid,
//              locked, err, err_count, slot_idx out)
module scan_demux
    import scan_demux_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic      CLK,
    input  logic      RST,
    scan_demux_if.slave bus
);
    state_t             state, state_n;
    logic [IDX_W-1:0]   expected, expected_n;
    logic [3:0]         sel_prev;
    logic [W-1:0]       slot [NSLOT];
    logic [4*W-1:0]     frame_out;
    logic               frame_valid;
    logic               err;
    logic [ERR_W-1:0]   err_count;
    logic [IDX_W-1:0]   slot_idx;

    logic               legal;
    logic [IDX_W-1:0]   idx;
    logic               cap, publish, viol;

    onehot_enc4 u_enc (
        .sel   (bus.sel),
        .legal (legal),
        .idx   (idx)
    );

    always_comb begin
        state_n    = state;
        expected_n = expected;
        cap        = 1'b0;
        publish    = 1'b0;
        viol       = 1'b0;
        unique case (state)
            HUNT: begin
                if (bus.sel == 4'b0001) begin
                    cap        = 1'b1;
                    expected_n = 2'd1;
                    state_n    = LOCKED;
                end
            end
            LOCKED: begin
                if (legal && (bus.sel == sel_prev)) begin
                    cap = 1'b1;                    // dwell: overwrite, no advance
                end else if (legal && (idx == expected)) begin
                    cap        = 1'b1;
                    expected_n = expected + 2'd1;
                    publish    = (idx == 2'd3);
                end else begin
                    viol = 1'b1;
                    // A violating slot-0 select doubles as a fresh lock.
                    if (bus.sel == 4'b0001) begin
                        cap        = 1'b1;
                        expected_n = 2'd1;
                    end else begin
                        state_n = HUNT;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= HUNT;
            expected    <= '0;
            sel_prev    <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            slot_idx    <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) slot[i] <= '0;
        end else begin
            state       <= state_n;
            expected    <= expected_n;
            sel_prev    <= bus.sel;
            frame_valid <= publish;
            err         <= viol;
            if (legal) slot_idx <= idx;
            if (cap) slot[idx] <= bus.data_in;
            // Slot 3 is taken straight from the bus so the frame is out one cycle after it.
            if (publish) frame_out <= {bus.data_in, slot[2], slot[1], slot[0]};
            if (viol && (err_count != '1)) err_count <= err_count + 1'b1;
        end
    end

    assign bus.frame_out   = frame_out;
    assign bus.frame_valid = frame_valid;
    assign bus.locked      = (state == LOCKED);
    assign bus.err         = err;
    assign bus.err_count   = err_count;
    assign bus.slot_idx    = slot_idx;

endmodule

// File: tb/tb_scan_demux.sv
// tb_scan_demux: directed bench for scan_demux (W=4) plus a second instance
// with ERR_W=2 for counter saturation.
module tb_scan_demux;

    logic CLK = 1'b0;
    logic RST;
    logic RST2;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    scan_demux_if #(.W(4), .ERR_W(8)) bus  ();
    scan_demux_if #(.W(4), .ERR_W(2)) bus2 ();

    scan_demux #(.W(4), .ERR_W(8)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    scan_demux #(.W(4), .ERR_W(2)) u_dut_sat (
        .CLK (CLK),
        .RST (RST2),
        .bus (bus2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge take them, sample 1 time unit later.
    task automatic step(input logic [3:0] s, input logic [3:0] d);
        bus.sel     = s;
        bus.data_in = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic step2(input logic [3:0] s, input logic [3:0] d);
        bus2.sel     = s;
        bus2.data_in = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frame"}, 32'(bus.frame_out), 32'h0);
        check({tag, "_fv"},    32'(bus.frame_valid), 32'h0);
        check({tag, "_lock"},  32'(bus.locked), 32'h0);
        check({tag, "_err"},   32'(bus.err), 32'h0);
        check({tag, "_ecnt"},  32'(bus.err_count), 32'h0);
        check({tag, "_idx"},   32'(bus.slot_idx), 32'h0);
    endtask

    initial begin
        int fv_cnt;
        int err_seen;
        logic [3:0] s;

        bus.sel = '0;  bus.data_in = '0;
        bus2.sel = '0; bus2.data_in = '0;
        RST = 1'b1; RST2 = 1'b1;
        step(4'b0000, 4'h0);
        step(4'b0000, 4'h0);
        check_zero("rst");
        RST = 1'b0;

        // 1: basic in-order scan
        step(4'b0001, 4'h1);
        check("t1_lock", 32'(bus.locked), 32'h1);
        check("t1_idx0", 32'(bus.slot_idx), 32'h0);
        step(4'b0010, 4'h2);
        check("t1_idx1", 32'(bus.slot_idx), 32'h1);
        step(4'b0100, 4'h3);
        check("t1_fv_early", 32'(bus.frame_valid), 32'h0);
        step(4'b1000, 4'h4);
        check("t1_fv", 32'(bus.frame_valid), 32'h1);
        check("t1_frame", 32'(bus.frame_out), 32'h4321);
        check("t1_err", 32'(bus.err), 32'h0);
        check("t1_idx3", 32'(bus.slot_idx), 32'h3);

        // 2: dwell 3 CLKs per slot, data 5,6,7,...,F,0
        fv_cnt = 0; err_seen = 0;
        for (int i = 0; i < 12; i++) begin
            s = 4'b0001 << (i / 3);
            step(s, 4'(5 + i));
            fv_cnt   += int'(bus.frame_valid);
            err_seen += int'(bus.err);
        end
        check("t2_fv_once", 32'(fv_cnt), 32'd1);
        check("t2_noerr", 32'(err_seen), 32'd0);
        check("t2_frame", 32'(bus.frame_out), 32'hEDA7);
        check("t2_lock", 32'(bus.locked), 32'h1);

        // 3: skipped slot 2
        step(4'b0001, 4'h1);
        step(4'b0010, 4'h2);
        step(4'b1000, 4'h3);
        check("t3_err", 32'(bus.err), 32'h1);
        check("t3_ecnt", 32'(bus.err_count), 32'h1);
        check("t3_lock", 32'(bus.locked), 32'h0);
        check("t3_fv", 32'(bus.frame_valid), 32'h0);
        check("t3_frame", 32'(bus.frame_out), 32'hEDA7);

        // 4: illegal codes in HUNT are ignored, in LOCKED they count
        step(4'b0000, 4'h0);
        check("t4_hunt0_err", 32'(bus.err), 32'h0);
        step(4'b0110, 4'h0);
        check("t4_hunt6_err", 32'(bus.err), 32'h0);
        check("t4_hunt_ecnt", 32'(bus.err_count), 32'h1);
        step(4'b0001, 4'h1);
        check("t4_relock", 32'(bus.locked), 32'h1);
        step(4'b0000, 4'h0);
        check("t4_lk0_err", 32'(bus.err), 32'h1);
        check("t4_lk0_ecnt", 32'(bus.err_count), 32'h2);
        step(4'b0001, 4'h1);
        check("t4_relock2_err", 32'(bus.err), 32'h0);
        step(4'b0110, 4'h0);
        check("t4_lk6_err", 32'(bus.err), 32'h1);
        check("t4_lk6_ecnt", 32'(bus.err_count), 32'h3);
        check("t4_lk6_idx", 32'(bus.slot_idx), 32'h0);

        // 5: out-of-order 0001 re-locks immediately
        step(4'b0001, 4'h1);
        step(4'b0010, 4'h2);
        step(4'b0001, 4'h9);
        check("t5_err", 32'(bus.err), 32'h1);
        check("t5_ecnt", 32'(bus.err_count), 32'h4);
        check("t5_lock", 32'(bus.locked), 32'h1);
        step(4'b0010, 4'h8);
        check("t5_err_clr", 32'(bus.err), 32'h0);
        step(4'b0100, 4'h7);
        step(4'b1000, 4'h6);
        check("t5_fv", 32'(bus.frame_valid), 32'h1);
        check("t5_frame", 32'(bus.frame_out), 32'h6789);
        step(4'b1000, 4'h5);
        check("t5_dwell3_fv", 32'(bus.frame_valid), 32'h0);

        // 6: reset mid-frame, then clean scan
        step(4'b0001, 4'h1);
        step(4'b0010, 4'h2);
        RST = 1'b1;
        step(4'b0100, 4'h3);
        check_zero("t6_rst");
        RST = 1'b0;
        step(4'b0001, 4'hA);
        step(4'b0010, 4'hB);
        step(4'b0100, 4'hC);
        step(4'b1000, 4'hD);
        check("t6_fv", 32'(bus.frame_valid), 32'h1);
        check("t6_frame", 32'(bus.frame_out), 32'hDCBA);

        // Saturation on the ERR_W=2 instance: 5 violations, count holds at 3
        RST2 = 1'b0;
        step2(4'b0001, 4'h1);
        check("sat_lock", 32'(bus2.locked), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            step2(4'b0010, 4'h2);
            step2(4'b0001, 4'h3);
            check($sformatf("sat_err%0d", k), 32'(bus2.err), 32'h1);
            check($sformatf("sat_cnt%0d", k), 32'(bus2.err_count), 32'((k > 3) ? 3 : k));
        end
        check("sat_lock_end", 32'(bus2.locked), 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
